// File: rtl/serial_frame_receiver.sv
// Framed byte receiver: assembles FRAME_BYTES strobed bytes into a frame and
// publishes it atomically with a valid/ack handshake, inter-byte timeout and overrun flag.
module serial_frame_receiver #(
    parameter int FRAME_BYTES    = 64,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 7,
    parameter int TMO_W          = 20
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    output logic [FRAME_BYTES*8-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ack,
    output logic                     frame_abort,
    output logic                     overrun,
    input  logic                     overrun_clr,
    output logic [CNT_W-1:0]         byte_count
);

    localparam int W = FRAME_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    // Abort fires on the edge where the idle count would reach the limit.
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [W-1:0]     staging;
    logic [W-1:0]     staging_nx;
    logic [W-1:0]     shifted;
    logic [W-1:0]     frame_data_nx;
    logic             frame_valid_nx;
    logic             frame_abort_nx;
    logic             overrun_nx;
    logic [CNT_W-1:0] byte_count_nx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nx;
    logic             complete;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            staging     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
            overrun     <= 1'b0;
            byte_count  <= '0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_nx;
            staging     <= staging_nx;
            frame_data  <= frame_data_nx;
            frame_valid <= frame_valid_nx;
            frame_abort <= frame_abort_nx;
            overrun     <= overrun_nx;
            byte_count  <= byte_count_nx;
            tmo_cnt     <= tmo_cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        staging_nx     = staging;
        frame_data_nx  = frame_data;
        byte_count_nx  = byte_count;
        tmo_cnt_nx     = tmo_cnt;
        frame_abort_nx = 1'b0;
        shifted        = {staging[W-9:0], rx_data};
        complete       = rx_ready && (byte_count == LAST_BYTE);

        if (rx_ready) begin
            staging_nx = shifted;
            tmo_cnt_nx = '0;
            if (complete) begin
                frame_data_nx = shifted;
                byte_count_nx = '0;
                state_nx      = IDLE;
            end else begin
                byte_count_nx = byte_count + CNT_W'(1);
                state_nx      = RECV;
            end
        end else if (state == RECV && TIMEOUT_CYCLES != 0) begin
            if (tmo_cnt == TMO_LAST) begin
                byte_count_nx  = '0;
                tmo_cnt_nx     = '0;
                state_nx       = IDLE;
                frame_abort_nx = 1'b1;
            end else begin
                tmo_cnt_nx = tmo_cnt + TMO_W'(1);
            end
        end

        // A new frame always wins over ack; ack on the same edge just
        // means the previous frame was consumed, so no overrun.
        if (complete) begin
            frame_valid_nx = 1'b1;
        end else if (frame_ack) begin
            frame_valid_nx = 1'b0;
        end else begin
            frame_valid_nx = frame_valid;
        end

        if (complete && frame_valid && !frame_ack) begin
            overrun_nx = 1'b1;
        end else if (overrun_clr) begin
            overrun_nx = 1'b0;
        end else begin
            overrun_nx = overrun;
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomized bench for serial_frame_receiver with a queue-based frame model
// and per-cycle output comparison, plus directed scenarios pinned to literals.
module tb_serial_frame_receiver;

    localparam int FB  = 4;
    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ack;
    logic        frame_abort;
    logic        overrun;
    logic        overrun_clr;
    logic [2:0]  byte_count;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    logic [7:0]  q[$];
    int          idle;
    logic [31:0] m_data;
    bit          m_valid;
    bit          m_abort;
    bit          m_ovr;

    serial_frame_receiver #(
        .FRAME_BYTES(FB),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(3),
        .TMO_W(6)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_ack(frame_ack),
        .frame_abort(frame_abort),
        .overrun(overrun),
        .overrun_clr(overrun_clr),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        idle    = 0;
        m_data  = '0;
        m_valid = 0;
        m_abort = 0;
        m_ovr   = 0;
    endtask

    // Frame-level view: a queue of bytes received so far, an idle counter,
    // and the published frame with its flags.
    task automatic model_step();
        bit done;
        done    = 0;
        m_abort = 0;
        if (overrun_clr) m_ovr = 0;
        if (rx_ready) begin
            q.push_back(rx_data);
            idle = 0;
            if (q.size() == FB) begin
                if (m_valid && !frame_ack) m_ovr = 1;
                m_data = {q[0], q[1], q[2], q[3]};
                q.delete();
                done = 1;
            end
        end else if (q.size() > 0) begin
            idle++;
            if (idle == TMO) begin
                q.delete();
                idle    = 0;
                m_abort = 1;
            end
        end
        if (done) m_valid = 1;
        else if (frame_ack) m_valid = 0;
    endtask

    task automatic cyc(input logic [7:0] d, input bit rdy,
                       input bit ack = 0, input bit clr = 0);
        rx_data     = d;
        rx_ready    = rdy;
        frame_ack   = ack;
        overrun_clr = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap = 0);
        for (int i = 0; i < FB; i++) begin
            cyc(f[31-8*i -: 8], 1'b1);
            if (i < FB - 1) repeat (gap) cyc(8'h00, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_data", frame_data, m_data);
            chk("cmp_valid", {31'b0, frame_valid}, {31'b0, m_valid});
            chk("cmp_abort", {31'b0, frame_abort}, {31'b0, m_abort});
            chk("cmp_overrun", {31'b0, overrun}, {31'b0, m_ovr});
            chk("cmp_count", {29'b0, byte_count}, 32'(q.size()));
        end
    end

    initial begin
        reset_n     = 1'b0;
        rx_data     = '0;
        rx_ready    = 1'b0;
        frame_ack   = 1'b0;
        overrun_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_on  = 1;

        // Scenario 1: reset mid-frame, then a clean frame
        cyc(8'h11, 1'b1);
        cyc(8'h22, 1'b1);
        chk("s1_pre_count", {29'b0, byte_count}, 32'd2);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("s1_rst_data", frame_data, 32'h0);
        chk("s1_rst_flags", {28'b0, frame_valid, frame_abort, overrun, 1'b0}, 32'h0);
        chk("s1_rst_count", {29'b0, byte_count}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        send_frame(32'h11223344);
        chk("s1_data", frame_data, 32'h11223344);
        chk("s1_valid", {31'b0, frame_valid}, 32'd1);
        chk("s1_count", {29'b0, byte_count}, 32'd0);
        chk("s1_pin", m_data, 32'h11223344);

        // Scenario 2: ack, then a redundant ack
        cyc(8'h00, 1'b0, 1'b1);
        chk("s2_valid", {31'b0, frame_valid}, 32'd0);
        chk("s2_data", frame_data, 32'h11223344);
        cyc(8'h00, 1'b0, 1'b1);
        chk("s2_valid2", {31'b0, frame_valid}, 32'd0);
        chk("s2_data2", frame_data, 32'h11223344);

        // Scenario 3: partial frame times out
        cyc(8'hAA, 1'b1);
        cyc(8'hBB, 1'b1);
        repeat (TMO - 1) cyc(8'h00, 1'b0);
        chk("s3_no_early_abort", {31'b0, frame_abort}, 32'd0);
        cyc(8'h00, 1'b0);
        chk("s3_abort", {31'b0, frame_abort}, 32'd1);
        chk("s3_count", {29'b0, byte_count}, 32'd0);
        chk("s3_pin_abort", {31'b0, m_abort}, 32'd1);
        cyc(8'h00, 1'b0);
        chk("s3_abort_end", {31'b0, frame_abort}, 32'd0);
        send_frame(32'h01020304);
        chk("s3_data", frame_data, 32'h01020304);
        cyc(8'h00, 1'b0, 1'b1);

        // Scenario 4: bytes land on the last idle clock before the limit
        send_frame(32'hC1C2C3C4, TMO - 1);
        chk("s4_data", frame_data, 32'hC1C2C3C4);
        chk("s4_valid", {31'b0, frame_valid}, 32'd1);
        chk("s4_pin", m_data, 32'hC1C2C3C4);
        cyc(8'h00, 1'b0, 1'b1);

        // Scenario 5: overrun and clear
        send_frame(32'h11223344);
        chk("s5_no_ovr", {31'b0, overrun}, 32'd0);
        send_frame(32'h55667788);
        chk("s5_data", frame_data, 32'h55667788);
        chk("s5_valid", {31'b0, frame_valid}, 32'd1);
        chk("s5_ovr", {31'b0, overrun}, 32'd1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        chk("s5_clr", {31'b0, overrun}, 32'd0);

        // Scenario 6: ack coincides with the completing byte
        cyc(8'h9A, 1'b1);
        cyc(8'hBC, 1'b1);
        cyc(8'hDE, 1'b1);
        cyc(8'hF0, 1'b1, 1'b1);
        chk("s6_valid", {31'b0, frame_valid}, 32'd1);
        chk("s6_data", frame_data, 32'h9ABCDEF0);
        chk("s6_ovr", {31'b0, overrun}, 32'd0);
        chk("s6_pin", m_data, 32'h9ABCDEF0);

        // Random traffic: alternating dense and sparse byte streams
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 200; i++) begin
                bit rdy;
                rdy = (b % 2 == 0) ? ($urandom_range(0, 1) == 1)
                                   : ($urandom_range(0, 59) == 0);
                cyc(8'($urandom_range(0, 255)), rdy,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            end
        end

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Parametrised framed byte receiver that replaces free-running shift-register work input.
- Sits between async_receiver (byte strobe interface) and the hashing core.
- Assembles a fixed-length frame of FRAME_BYTES bytes into a staging buffer, then publishes the whole frame atomically to a holding register with a valid/ack handshake.
- Adds an inter-byte timeout that discards partial frames, and a sticky overrun flag.

Parameters:
- FRAME_BYTES, 64, bytes per frame; must be ≥ 2.
- TIMEOUT_CYCLES, 1000000, idle clocks after a byte before a partial frame is discarded; 0 disables the timeout.
- CNT_W, 7, byte-counter width; must satisfy 2^CNT_W > FRAME_BYTES.
- TMO_W, 20, timeout-counter width; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from async_receiver.
- rx_ready  in  1  one-cycle strobe; rx_data is valid this cycle.
- frame_data  out  FRAME_BYTES*8  last published frame; first byte received in MSBs [FRAME_BYTES*8-1 -: 8], last byte in [7:0].
- frame_valid  out  1  level; a published frame is pending consumption.
- frame_ack  in  1  consumer accepts the frame; clears frame_valid.
- frame_abort  out  1  one-cycle pulse when a partial frame is discarded by timeout.
- overrun  out  1  sticky; a frame was published while frame_valid was still high.
- overrun_clr  in  1  clears overrun.
- byte_count  out  CNT_W  bytes accepted into the current partial frame.

Behaviour:
- Reset (async, reset_n=0): frame_data=0, frame_valid=0, frame_abort=0, overrun=0, byte_count=0, staging buffer=0, timeout counter=0. All state returns to IDLE immediately; a partial frame in progress is lost.
- States:
  - IDLE: byte_count=0. On rx_ready, go to RECV.
  - RECV: accumulating bytes.
- Byte acceptance (IDLE or RECV, rx_ready=1):
  - staging <= {staging[FRAME_BYTES*8-9:0], rx_data}.
  - byte_count increments and the timeout counter clears.
- Completion: when the accepted byte makes byte_count reach FRAME_BYTES, in that same edge:
  - frame_data <= new staging value, including the current byte;
  - byte_count <= 0, state <= IDLE, frame_valid <= 1.
  - frame_data is stable from the cycle after the completing rx_ready; completion latency is 1 clock.
- Handshake:
  - frame_valid stays high until a cycle with frame_ack=1, then drops on the next edge.
  - frame_ack while frame_valid=0 is ignored.
  - frame_data is held unchanged until the next completion, never cleared by ack.
- Simultaneous completion and frame_ack on the same edge: frame_valid stays 1 and the new frame is published. overrun is not set, because the old frame counts as consumed.
- Overrun: completion while frame_valid=1 and frame_ack=0 overwrites frame_data and sets overrun=1. overrun holds until overrun_clr. overrun_clr and a new overrun on the same edge leave overrun=1.
- Timeout (TIMEOUT_CYCLES>0):
  - In RECV, the timeout counter increments every clock without rx_ready.
  - When it reaches TIMEOUT_CYCLES: byte_count <= 0, state <= IDLE, counter <= 0, frame_abort pulses for exactly 1 clock.
  - frame_data and frame_valid are unaffected.
  - If rx_ready arrives in the same cycle the count would hit the limit, the byte wins: it is accepted, with no abort.
  - The counter does not run in IDLE.
- TIMEOUT_CYCLES=0: no aborts ever. Behaviour degenerates to a pure byte-counting framer.
- The staging buffer is not cleared on abort or completion; only byte_count governs framing.

Test Plan:
- Bench parameters: FRAME_BYTES=4, TIMEOUT_CYCLES=50.
- Scenario 1: reset_n=0 mid-frame after 2 bytes → all outputs 0 immediately; after release, bytes 11,22,33,44 → frame_data=32'h11223344, frame_valid=1 one clock after the 4th strobe, byte_count=0.
- Scenario 2: frame 11223344 pending, frame_ack pulsed → frame_valid=0 next clock, frame_data still 11223344; a second ack while frame_valid=0 has no effect.
- Scenario 3: bytes AA,BB, then 50 idle clocks → frame_abort single pulse on the 50th idle clock, byte_count=0. Next bytes 01,02,03,04 → frame_data=32'h01020304, no stale AA/BB.
- Scenario 4: bytes at 49-clock gaps → no abort, frame completes. Byte arriving exactly on the 50th idle clock → accepted, no abort.
- Scenario 5: frame A=11223344 not acked, frame B=55667788 completes → frame_data=55667788, frame_valid=1, overrun=1. overrun_clr → overrun=0.
- Scenario 6: frame_ack asserted in the same cycle as the completing byte of frame 9ABCDEF0 while an older frame is pending → frame_valid=1, frame_data=32'h9ABCDEF0, overrun=0.
